// File: rtl/fetch_controller_if.sv
// Fetch controller bus: hazard/branch/interrupt inputs and PC-override outputs.
interface fetch_controller_if;
    logic        hazard_stall;
    logic        mem_stall;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic        interrupt;
    logic [15:0] int_vector_addr;
    logic [15:0] pc_current;
    logic        pc_enable;
    logic        pc_write;
    logic [15:0] pc_write_back_value;
    logic        clear_instruction;
    logic        int_ack;
    logic [15:0] saved_pc;
    logic        busy;

    // The controller itself
    modport master (
        input  hazard_stall, mem_stall, branch_taken, branch_target,
               interrupt, int_vector_addr, pc_current,
        output pc_enable, pc_write, pc_write_back_value,
               clear_instruction, int_ack, saved_pc, busy
    );

    // The surrounding pipeline (hazard unit, execute stage, fetch stage)
    modport slave (
        output hazard_stall, mem_stall, branch_taken, branch_target,
               interrupt, int_vector_addr, pc_current,
        input  pc_enable, pc_write, pc_write_back_value,
               clear_instruction, int_ack, saved_pc, busy
    );
endinterface

// File: rtl/fetch_controller.sv
// Fetch-stage sequencing controller: boot vector, branch redirect,
// interrupt drain/entry and memory/hazard stalls.
module fetch_controller #(
    parameter logic [15:0] RESET_VECTOR     = 16'h0000,
    parameter int          INT_DRAIN_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    fetch_controller_if.master        bus
);

    typedef enum logic [2:0] {
        BOOT,
        RUN,
        STALL,
        INT_DRAIN,
        INT_JUMP
    } state_t;

    localparam logic [2:0] DRAIN_INIT = 3'(INT_DRAIN_CYCLES - 1);

    state_t      state_q, state_d;
    logic [15:0] saved_pc_q, saved_pc_d;
    logic        pending_valid_q, pending_valid_d;
    logic [15:0] pending_target_q, pending_target_d;
    logic [2:0]  drain_cnt_q, drain_cnt_d;

    logic        pc_enable_c;
    logic        pc_write_c;
    logic [15:0] pc_value_c;
    logic        clear_c;
    logic        int_ack_c;

    // State and bookkeeping registers; reset drops any pending redirect or interrupt entry
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= BOOT;
            saved_pc_q       <= 16'h0000;
            pending_valid_q  <= 1'b0;
            pending_target_q <= 16'h0000;
            drain_cnt_q      <= 3'd0;
        end else begin
            state_q          <= state_d;
            saved_pc_q       <= saved_pc_d;
            pending_valid_q  <= pending_valid_d;
            pending_target_q <= pending_target_d;
            drain_cnt_q      <= drain_cnt_d;
        end
    end

    // Next-state and fetch-control outputs; RUN priority is branch > interrupt > mem stall > hazard
    always_comb begin
        state_d          = state_q;
        saved_pc_d       = saved_pc_q;
        pending_valid_d  = pending_valid_q;
        pending_target_d = pending_target_q;
        drain_cnt_d      = drain_cnt_q;
        pc_enable_c      = 1'b0;
        pc_write_c       = 1'b0;
        pc_value_c       = 16'h0000;
        clear_c          = 1'b0;
        int_ack_c        = 1'b0;

        case (state_q)
            BOOT: begin
                pc_enable_c = 1'b1;
                pc_write_c  = 1'b1;
                pc_value_c  = RESET_VECTOR;
                clear_c     = 1'b1;
                state_d     = RUN;
            end
            RUN: begin
                if (bus.branch_taken || pending_valid_q) begin
                    pc_enable_c     = 1'b1;
                    pc_write_c      = 1'b1;
                    pc_value_c      = bus.branch_taken ? bus.branch_target : pending_target_q;
                    clear_c         = 1'b1;
                    pending_valid_d = 1'b0;
                end else if (bus.interrupt) begin
                    clear_c     = 1'b1;
                    saved_pc_d  = bus.pc_current;
                    drain_cnt_d = DRAIN_INIT;
                    state_d     = INT_DRAIN;
                end else if (bus.mem_stall) begin
                    state_d = STALL;
                end else if (!bus.hazard_stall) begin
                    pc_enable_c = 1'b1;
                end
            end
            STALL: begin
                if (bus.branch_taken) begin
                    pending_valid_d  = 1'b1;
                    pending_target_d = bus.branch_target;
                end
                if (!bus.mem_stall) begin
                    state_d = RUN;
                end
            end
            INT_DRAIN: begin
                clear_c = 1'b1;
                if (bus.branch_taken) begin
                    saved_pc_d = bus.branch_target;
                end
                if (drain_cnt_q == 3'd0) begin
                    state_d = INT_JUMP;
                end else begin
                    drain_cnt_d = drain_cnt_q - 3'd1;
                end
            end
            INT_JUMP: begin
                pc_enable_c = 1'b1;
                pc_write_c  = 1'b1;
                pc_value_c  = bus.int_vector_addr;
                clear_c     = 1'b1;
                int_ack_c   = 1'b1;
                state_d     = RUN;
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    assign bus.pc_enable           = pc_enable_c;
    assign bus.pc_write            = pc_write_c;
    assign bus.pc_write_back_value = pc_value_c;
    assign bus.clear_instruction   = clear_c;
    assign bus.int_ack             = int_ack_c;
    assign bus.saved_pc            = saved_pc_q;
    assign bus.busy                = (state_q != RUN);

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller: directed vectors with literal
// expectations plus a cycle-by-cycle comparison against a behavioural model.
module tb_fetch_controller;

    localparam logic [15:0] RESET_VECTOR     = 16'h0000;
    localparam int          INT_DRAIN_CYCLES = 2;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    fetch_controller_if bus ();

    fetch_controller #(
        .RESET_VECTOR     (RESET_VECTOR),
        .INT_DRAIN_CYCLES (INT_DRAIN_CYCLES)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural model: tracks what the fetch stage is doing in terms of
    // remaining boot/drain/jump cycles and a remembered redirect
    logic        m_valid;
    logic        m_boot;
    logic        m_jump;
    logic        m_stalled;
    int          m_drain_left;
    logic        m_pending;
    logic [15:0] m_pending_addr;
    logic [15:0] m_saved;

    initial begin
        m_valid        = 1'b0;
        m_boot         = 1'b0;
        m_jump         = 1'b0;
        m_stalled      = 1'b0;
        m_drain_left   = 0;
        m_pending      = 1'b0;
        m_pending_addr = 16'h0000;
        m_saved        = 16'h0000;
    end

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got 0x%04h, expected 0x%04h", name, $time, actual, expected);
        end
    endtask

    // Advance the model on each rising edge from the inputs held during that cycle
    always @(posedge clk) begin
        if (reset) begin
            m_valid      = 1'b1;
            m_boot       = 1'b1;
            m_jump       = 1'b0;
            m_stalled    = 1'b0;
            m_drain_left = 0;
            m_pending    = 1'b0;
            m_saved      = 16'h0000;
        end else if (m_valid) begin
            if (m_boot) begin
                m_boot = 1'b0;
            end else if (m_jump) begin
                m_jump = 1'b0;
            end else if (m_drain_left > 0) begin
                if (bus.branch_taken) m_saved = bus.branch_target;
                m_drain_left = m_drain_left - 1;
                if (m_drain_left == 0) m_jump = 1'b1;
            end else if (m_stalled) begin
                if (bus.branch_taken) begin
                    m_pending      = 1'b1;
                    m_pending_addr = bus.branch_target;
                end
                if (!bus.mem_stall) m_stalled = 1'b0;
            end else begin
                if (bus.branch_taken || m_pending) begin
                    m_pending = 1'b0;
                end else if (bus.interrupt) begin
                    m_saved      = bus.pc_current;
                    m_drain_left = INT_DRAIN_CYCLES;
                end else if (bus.mem_stall) begin
                    m_stalled = 1'b1;
                end
            end
        end
    end

    // Compare every DUT output against the model on each falling edge
    always @(negedge clk) begin
        logic        e_en, e_wr, e_clr, e_ack, e_busy;
        logic [15:0] e_val;
        if (m_valid) begin
            e_en = 1'b0; e_wr = 1'b0; e_val = 16'h0000; e_clr = 1'b0; e_ack = 1'b0; e_busy = 1'b1;
            if (m_boot) begin
                e_en = 1'b1; e_wr = 1'b1; e_val = RESET_VECTOR; e_clr = 1'b1;
            end else if (m_jump) begin
                e_en = 1'b1; e_wr = 1'b1; e_val = bus.int_vector_addr; e_clr = 1'b1; e_ack = 1'b1;
            end else if (m_drain_left > 0) begin
                e_clr = 1'b1;
            end else if (!m_stalled) begin
                e_busy = 1'b0;
                if (bus.branch_taken) begin
                    e_en = 1'b1; e_wr = 1'b1; e_val = bus.branch_target; e_clr = 1'b1;
                end else if (m_pending) begin
                    e_en = 1'b1; e_wr = 1'b1; e_val = m_pending_addr; e_clr = 1'b1;
                end else if (bus.interrupt) begin
                    e_clr = 1'b1;
                end else if (!bus.mem_stall && !bus.hazard_stall) begin
                    e_en = 1'b1;
                end
            end
            checkOutput("model pc_enable", 16'(bus.pc_enable), 16'(e_en));
            checkOutput("model pc_write", 16'(bus.pc_write), 16'(e_wr));
            checkOutput("model pc_write_back_value", bus.pc_write_back_value, e_val);
            checkOutput("model clear_instruction", 16'(bus.clear_instruction), 16'(e_clr));
            checkOutput("model int_ack", 16'(bus.int_ack), 16'(e_ack));
            checkOutput("model busy", 16'(bus.busy), 16'(e_busy));
            checkOutput("model saved_pc", bus.saved_pc, m_saved);
        end
    end

    // Drive one cycle of inputs just after the rising edge, then wait for the falling edge
    task automatic applyStimulus(input logic rst, input logic hz, input logic ms, input logic br,
                                 input logic [15:0] tgt, input logic intr, input logic [15:0] iv,
                                 input logic [15:0] pcc);
        @(posedge clk);
        #1;
        reset               = rst;
        bus.hazard_stall    = hz;
        bus.mem_stall       = ms;
        bus.branch_taken    = br;
        bus.branch_target   = tgt;
        bus.interrupt       = intr;
        bus.int_vector_addr = iv;
        bus.pc_current      = pcc;
        @(negedge clk);
    endtask

    // Directed scenarios with literal expectations, then a randomised tail checked by the model
    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        bus.hazard_stall = 1'b0; bus.mem_stall = 1'b0; bus.branch_taken = 1'b0;
        bus.branch_target = 16'h0000; bus.interrupt = 1'b0;
        bus.int_vector_addr = 16'h0200; bus.pc_current = 16'h0000;

        $display("[TB] boot");
        applyStimulus(1, 0, 0, 0, 16'h0000, 0, 16'h0200, 16'h0000);
        applyStimulus(0, 0, 0, 0, 16'h0000, 0, 16'h0200, 16'h0000);
        checkOutput("boot pc_write", 16'(bus.pc_write), 16'd1);
        checkOutput("boot value", bus.pc_write_back_value, 16'h0000);
        checkOutput("boot clear", 16'(bus.clear_instruction), 16'd1);
        checkOutput("boot busy", 16'(bus.busy), 16'd1);
        applyStimulus(0, 0, 0, 0, 16'h0000, 0, 16'h0200, 16'h0001);
        checkOutput("run pc_enable", 16'(bus.pc_enable), 16'd1);
        checkOutput("run pc_write", 16'(bus.pc_write), 16'd0);
        checkOutput("run busy", 16'(bus.busy), 16'd0);

        $display("[TB] branch redirect");
        applyStimulus(0, 0, 0, 1, 16'h0080, 0, 16'h0200, 16'h0002);
        checkOutput("branch pc_write", 16'(bus.pc_write), 16'd1);
        checkOutput("branch value", bus.pc_write_back_value, 16'h0080);
        checkOutput("branch clear", 16'(bus.clear_instruction), 16'd1);
        applyStimulus(0, 0, 0, 0, 16'h0000, 0, 16'h0200, 16'h0080);
        checkOutput("after branch value", bus.pc_write_back_value, 16'h0000);

        $display("[TB] stall with pending branch");
        applyStimulus(0, 0, 1, 0, 16'h0000, 0, 16'h0200, 16'h0081);
        checkOutput("stall1 pc_enable", 16'(bus.pc_enable), 16'd0);
        checkOutput("stall1 clear", 16'(bus.clear_instruction), 16'd0);
        applyStimulus(0, 0, 1, 1, 16'h0032, 0, 16'h0200, 16'h0081);
        checkOutput("stall2 pc_enable", 16'(bus.pc_enable), 16'd0);
        checkOutput("stall2 pc_write", 16'(bus.pc_write), 16'd0);
        applyStimulus(0, 0, 1, 0, 16'h0000, 0, 16'h0200, 16'h0081);
        checkOutput("stall3 pc_enable", 16'(bus.pc_enable), 16'd0);
        applyStimulus(0, 0, 0, 0, 16'h0000, 0, 16'h0200, 16'h0081);
        checkOutput("stall release busy", 16'(bus.busy), 16'd1);
        applyStimulus(0, 0, 0, 0, 16'h0000, 0, 16'h0200, 16'h0081);
        checkOutput("pending pc_write", 16'(bus.pc_write), 16'd1);
        checkOutput("pending value", bus.pc_write_back_value, 16'h0032);
        applyStimulus(0, 0, 0, 0, 16'h0000, 0, 16'h0200, 16'h0032);
        checkOutput("pending cleared", 16'(bus.pc_write), 16'd0);

        $display("[TB] hazard and mem stall together");
        applyStimulus(0, 1, 1, 0, 16'h0000, 0, 16'h0200, 16'h0033);
        checkOutput("hz+ms pc_enable", 16'(bus.pc_enable), 16'd0);
        applyStimulus(0, 0, 0, 0, 16'h0000, 0, 16'h0200, 16'h0033);
        checkOutput("hz+ms in stall", 16'(bus.busy), 16'd1);
        applyStimulus(0, 0, 0, 0, 16'h0000, 0, 16'h0200, 16'h0033);
        checkOutput("hz+ms released", 16'(bus.pc_enable), 16'd1);

        $display("[TB] interrupt entry");
        applyStimulus(0, 0, 0, 0, 16'h0000, 1, 16'h0200, 16'h0010);
        checkOutput("int sample clear", 16'(bus.clear_instruction), 16'd1);
        checkOutput("int sample pc_enable", 16'(bus.pc_enable), 16'd0);
        for (int i = 0; i < INT_DRAIN_CYCLES; i++) begin
            applyStimulus(0, 0, 0, 0, 16'h0000, 1, 16'h0200, 16'h0010);
            checkOutput("drain clear", 16'(bus.clear_instruction), 16'd1);
            checkOutput("drain pc_enable", 16'(bus.pc_enable), 16'd0);
            checkOutput("drain int_ack", 16'(bus.int_ack), 16'd0);
        end
        applyStimulus(0, 0, 0, 0, 16'h0000, 1, 16'h0200, 16'h0010);
        checkOutput("jump int_ack", 16'(bus.int_ack), 16'd1);
        checkOutput("jump value", bus.pc_write_back_value, 16'h0200);
        checkOutput("jump saved_pc", bus.saved_pc, 16'h0010);
        applyStimulus(0, 0, 0, 0, 16'h0000, 0, 16'h0200, 16'h0200);
        checkOutput("after jump int_ack", 16'(bus.int_ack), 16'd0);

        $display("[TB] branch during drain");
        applyStimulus(0, 0, 0, 0, 16'h0000, 1, 16'h0300, 16'h0020);
        applyStimulus(0, 0, 1, 1, 16'h0044, 1, 16'h0300, 16'h0020);
        applyStimulus(0, 0, 0, 0, 16'h0000, 1, 16'h0300, 16'h0020);
        checkOutput("drain branch saved_pc", bus.saved_pc, 16'h0044);
        applyStimulus(0, 0, 0, 0, 16'h0000, 1, 16'h0300, 16'h0020);
        checkOutput("drain branch ack", 16'(bus.int_ack), 16'd1);
        checkOutput("drain branch vector", bus.pc_write_back_value, 16'h0300);

        $display("[TB] reset mid-drain");
        applyStimulus(0, 0, 0, 0, 16'h0000, 1, 16'h0300, 16'h0030);
        applyStimulus(0, 0, 0, 0, 16'h0000, 1, 16'h0300, 16'h0030);
        applyStimulus(1, 0, 0, 0, 16'h0000, 1, 16'h0300, 16'h0030);
        applyStimulus(0, 0, 0, 0, 16'h0000, 0, 16'h0300, 16'h0030);
        checkOutput("reset drain int_ack", 16'(bus.int_ack), 16'd0);
        checkOutput("reset drain saved_pc", bus.saved_pc, 16'h0000);
        checkOutput("reset drain boot value", bus.pc_write_back_value, 16'h0000);
        checkOutput("reset drain busy", 16'(bus.busy), 16'd1);
        applyStimulus(0, 0, 0, 0, 16'h0000, 0, 16'h0300, 16'h0000);
        checkOutput("reset drain run", 16'(bus.busy), 16'd0);

        $display("[TB] randomised mix");
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 63) == 0),
                          ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 4) == 0),
                          16'($urandom),
                          ($urandom_range(0, 5) == 0),
                          16'($urandom),
                          16'($urandom));
        end

        applyStimulus(0, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
